// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule, one round per clock, with an 11x128 round-key buffer and a registered indexed read port
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   key_in       128-bit cipher key (byte 0 in [127:120]), captured on an accepted key_load
//   key_load     start expansion; accepted in IDLE or READY, ignored while expanding
//   busy         high while the schedule is being expanded
//   keys_valid   high once all 11 round keys are in the buffer
//   rk_idx       round-key read index 0..10
//   rk_out       registered round key for the rk_idx sampled on the previous edge
//   rk_err       registered; high when the sampled rk_idx is above 10
module aes_key_expander #(
  parameter bit REVERSE_READ  = 1'b1,
  parameter bit CLEAR_ON_LOAD = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_err
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  // Forward AES S-box, entry 0 in the leftmost byte so index 255 holds sbox(0).
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [10:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };
  state_t       state;
  logic [3:0]   round;
  logic [127:0] rk [0:10];
  logic [127:0] nxt;
  logic [3:0]   ridx;
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] w, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    // SubWord(RotWord(w3)) ^ rcon, with w3 = {a,b,c,d} rotated to {b,c,d,a}
    t  = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h0};
    n0 = w[127:96] ^ t;
    n1 = w[95:64] ^ n0;
    n2 = w[63:32] ^ n1;
    n3 = w[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
  always_comb begin
    nxt  = next_key(rk[round - 4'd1], RCON[round]);
    ridx = REVERSE_READ ? 4'd10 - rk_idx : rk_idx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= 4'd0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else if (state == EXPAND) begin
      rk[round] <= nxt;
      round     <= round == 4'd10 ? 4'd0 : round + 4'd1;
      state     <= round == 4'd10 ? READY : EXPAND;
      busy      <= round != 4'd10;
      keys_valid <= round == 4'd10;
    end else if (key_load) begin
      if (CLEAR_ON_LOAD)
        for (int i = 1; i <= 10; i++) rk[i] <= '0;
      rk[0]      <= key_in;
      round      <= 4'd1;
      state      <= EXPAND;
      busy       <= 1'b1;
      keys_valid <= 1'b0;
    end
  end
  // Read port samples the buffer before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out <= '0;
      rk_err <= 1'b0;
    end else begin
      rk_out <= rk_idx > 4'd10 ? '0 : rk[ridx];
      rk_err <= rk_idx > 4'd10;
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed vectors for the AES-128 key expander in both read orders
module tb_aes_key_expander;
  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  typedef struct {
    logic [127:0] key;
    logic         rev;
    logic [3:0]   idx;
    logic [127:0] exp;
    logic         err;
  } vec_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic [3:0]   rk_idx = '0;
  logic         busy0, keys_valid0, rk_err0, busy1, keys_valid1, rk_err1;
  logic [127:0] rk_out0, rk_out1;
  int           n_cmp = 0;
  int           n_bad = 0;
  vec_t         tbl[$];
  always #5 clk = ~clk;
  aes_key_expander #(.REVERSE_READ(1'b0), .CLEAR_ON_LOAD(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load), .busy(busy0),
    .keys_valid(keys_valid0), .rk_idx(rk_idx), .rk_out(rk_out0), .rk_err(rk_err0)
  );
  aes_key_expander #(.REVERSE_READ(1'b1), .CLEAR_ON_LOAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load), .busy(busy1),
    .keys_valid(keys_valid1), .rk_idx(rk_idx), .rk_out(rk_out1), .rk_err(rk_err1)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [3:0] i);
    rk_idx = i;
    tick();
  endtask
  task automatic wait_valid(input int start, input string nm);
    int n = start;
    while (!keys_valid0 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 128'(n), 128'd10);
    chk({nm, "_busy_done"}, 128'(busy0), 128'd0);
  endtask
  task automatic load(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("load_busy", 128'(busy0), 128'd1);
    chk("load_kv", 128'(keys_valid0), 128'd0);
    wait_valid(0, "load");
  endtask
  initial begin
    logic [127:0] cur;
    bit           have;
    int           n;
    tbl.push_back('{'0, 1'b0, 4'd1, Z1, 1'b0});
    tbl.push_back('{'0, 1'b0, 4'd2, Z2, 1'b0});
    tbl.push_back('{'0, 1'b0, 4'd10, Z10, 1'b0});
    tbl.push_back('{'0, 1'b1, 4'd0, Z10, 1'b0});
    tbl.push_back('{'0, 1'b1, 4'd10, '0, 1'b0});
    tbl.push_back('{K, 1'b0, 4'd0, K, 1'b0});
    tbl.push_back('{K, 1'b0, 4'd1, R1, 1'b0});
    tbl.push_back('{K, 1'b0, 4'd2, R2, 1'b0});
    tbl.push_back('{K, 1'b0, 4'd10, R10, 1'b0});
    tbl.push_back('{K, 1'b1, 4'd0, R10, 1'b0});
    tbl.push_back('{K, 1'b1, 4'd9, R1, 1'b0});
    tbl.push_back('{K, 1'b1, 4'd10, K, 1'b0});
    tbl.push_back('{K, 1'b0, 4'd11, '0, 1'b1});
    tbl.push_back('{K, 1'b1, 4'd15, '0, 1'b1});
    repeat (3) tick();
    chk("rst_busy", 128'(busy0), 128'd0);
    chk("rst_kv", 128'(keys_valid0), 128'd0);
    chk("rst_rk_out", rk_out0, '0);
    chk("rst_rk_err", 128'(rk_err0), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(4'd5);
    chk("idle_read", rk_out0, '0);
    have = 1'b0;
    cur  = '0;
    foreach (tbl[i]) begin
      if (!have || tbl[i].key !== cur) begin
        load(tbl[i].key);
        cur  = tbl[i].key;
        have = 1'b1;
      end
      rd(tbl[i].idx);
      chk($sformatf("vec%0d_rk", i), tbl[i].rev ? rk_out1 : rk_out0, tbl[i].exp);
      chk($sformatf("vec%0d_err", i), 128'(tbl[i].rev ? rk_err1 : rk_err0), 128'(tbl[i].err));
    end
    // Reload from READY: the load edge reads the old entry, the next edge sees it cleared.
    rk_idx   = 4'd10;
    key_in   = '0;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("reload_kv_drop", 128'(keys_valid0), 128'd0);
    chk("reload_busy", 128'(busy0), 128'd1);
    chk("reload_prewrite", rk_out0, R10);
    tick();
    chk("reload_cleared", rk_out0, '0);
    wait_valid(1, "reload");
    rd(4'd1);
    chk("reload_idx1", rk_out0, Z1);
    rd(4'd10);
    chk("reload_idx10", rk_out0, Z10);
    // key_load with another key during expansion must be ignored.
    key_in   = K;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n = 0;
    while (!keys_valid0 && n < 20) begin
      if (n == 3) begin
        key_in   = 128'h00112233445566778899aabbccddeeff;
        key_load = 1'b1;
      end
      tick();
      key_load = 1'b0;
      n++;
    end
    chk("ignore_latency", 128'(n), 128'd10);
    rd(4'd1);
    chk("ignore_idx1", rk_out0, R1);
    rd(4'd10);
    chk("ignore_idx10", rk_out0, R10);
    // Reset in the middle of expansion.
    key_in   = '0;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (4) tick();
    chk("mid_busy", 128'(busy0), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy0), 128'd0);
    chk("arst_kv", 128'(keys_valid0), 128'd0);
    chk("arst_rk_out", rk_out0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_kv", 128'(keys_valid0), 128'd0);
    for (int i = 0; i <= 10; i++) begin
      rd(4'(i));
      chk($sformatf("post_rst_idx%0d", i), rk_out0 | rk_out1, '0);
    end
    for (int i = 11; i <= 15; i++) begin
      rd(4'(i));
      chk($sformatf("oor_rk%0d", i), rk_out0, '0);
      chk($sformatf("oor_err%0d", i), 128'(rk_err0 & rk_err1), 128'd1);
    end
    chk("post_rst_kv_end", 128'(keys_valid0 | busy0), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
